// File: rtl/ahb_region_decoder.sv
// ahb_region_decoder: AHB address decoder with data-phase tracking, burst hold, remap and split bookkeeping
module ahb_region_decoder #(
    parameter int SLV_NUM = 4,
    parameter int ADDR_W = 32,
    parameter logic [SLV_NUM*ADDR_W-1:0] REGION_BASE = '0,
    parameter logic [SLV_NUM*ADDR_W-1:0] REGION_MASK = '0,
    parameter int REMAP_SLV = 1,
    parameter int CNT_W = 8
) (
    input  logic               hclk,
    input  logic               hreset,
    input  logic [ADDR_W-1:0]  haddr,
    input  logic [1:0]         htrans,
    input  logic               hready,
    input  logic [1:0]         hresp,
    input  logic               hremap,
    input  logic [SLV_NUM-1:0] hsplit,
    output logic [SLV_NUM-1:0] hsel,
    output logic               default_slv_sel,
    output logic [SLV_NUM-1:0] hsel_dp,
    output logic               default_slv_dp,
    output logic [SLV_NUM-1:0] split_pend,
    output logic               remap_act,
    output logic [CNT_W-1:0]   dec_err_cnt
);
    typedef enum logic [1:0] {DP_IDLE, DP_SLV, DP_ERR} dp_state_t;
    localparam int RS = REMAP_SLV % SLV_NUM;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    dp_state_t state;
    logic [SLV_NUM-1:0] m, low, nsel, burst_sel;
    logic burst_def, xfer;
    always_comb begin
        m = '0;
        for (int i = 0; i < SLV_NUM; i++)
            m[i] = (haddr & REGION_MASK[i*ADDR_W +: ADDR_W]) == REGION_BASE[i*ADDR_W +: ADDR_W];
        low = m & (~m + 1'b1);
        nsel = low;
        if (remap_act) begin
            nsel[0] = low[RS];
            nsel[RS] = low[0];
        end
        hsel = hreset ? '0 : htrans == 2'b10 ? nsel : htrans[0] ? burst_sel : '0;
        default_slv_sel = !hreset && (htrans == 2'b10 ? ~|m : htrans[0] && burst_def);
    end
    assign xfer = hready && htrans[1];
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state <= DP_IDLE;
            hsel_dp <= '0;
            default_slv_dp <= 1'b0;
            split_pend <= '0;
            remap_act <= 1'b0;
            dec_err_cnt <= '0;
            burst_sel <= '0;
            burst_def <= 1'b0;
        end else begin
            if (hready && htrans == 2'b10) begin
                burst_sel <= nsel;
                burst_def <= ~|m;
            end
            if (hready) begin
                hsel_dp <= htrans[1] ? hsel : '0;
                default_slv_dp <= xfer && default_slv_sel;
                state <= !htrans[1] ? DP_IDLE : |hsel ? DP_SLV : default_slv_sel ? DP_ERR : DP_IDLE;
            end
            if (xfer && default_slv_sel && dec_err_cnt != CNT_MAX)
                dec_err_cnt <= dec_err_cnt + 1'b1;
            split_pend <= (split_pend & ~hsplit) | ({SLV_NUM{hready && hresp == 2'd3}} & hsel_dp);
            if (state == DP_IDLE && htrans == 2'b00)
                remap_act <= hremap;
        end
    end
endmodule

// File: doc/ahb_region_decoder.md
# ahb_region_decoder

Parametrised AHB address decoder with data-phase tracking, burst select hold, remap and split bookkeeping. It sits between each master-side address mux and the slave set. It generates address-phase slave selects and a registered data-phase select for the read-data/response mux. It routes unmapped accesses to the default slave and keeps a saturating decode-error count.

## Interface
Parameters:
- SLV_NUM, 4, number of mapped slaves (1..16)
- ADDR_W, 32, address width
- REGION_BASE, all 0, SLV_NUM x ADDR_W packed, base address of region i
- REGION_MASK, all 0, SLV_NUM x ADDR_W packed; region i matches when (haddr & REGION_MASK[i]) == REGION_BASE[i]
- REMAP_SLV, 1, slave index swapped with slave 0 while remap is active
- CNT_W, 8, width of decode-error counter

Ports:
- hclk, in, 1, clock
- hreset, in, 1, reset; one clock, reset is synchronous and active-high
- haddr, in, ADDR_W, address-phase address
- htrans, in, 2, IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
- hready, in, 1, transfer-done from the data-phase mux
- hresp, in, 2, OKAY=0, ERROR=1, RETRY=2, SPLIT=3 (data-phase slave)
- hremap, in, 1, remap request
- hsplit, in, SLV_NUM, per-slave split release pulse
- hsel, out, SLV_NUM, address-phase one-hot select (combinational)
- default_slv_sel, out, 1, address-phase default-slave select (combinational)
- hsel_dp, out, SLV_NUM, registered data-phase select
- default_slv_dp, out, 1, registered data-phase default select
- split_pend, out, SLV_NUM, slave i holds a split master
- remap_act, out, 1, registered remap state
- dec_err_cnt, out, CNT_W, saturating count of unmapped accesses

## Operation
- Match vector: m[i] = ((haddr & REGION_MASK[i]) == REGION_BASE[i]). Overlaps resolve to the lowest index.
- Remap: while remap_act=1, a match on region 0 selects slave REMAP_SLV, and a match on region REMAP_SLV selects slave 0.
- NONSEQ: hsel = one-hot of the resolved match. If there is no match, default_slv_sel=1 and hsel=0.
- SEQ/BUSY: hsel and default_slv_sel come from the burst register (the select latched at the last accepted NONSEQ). haddr is ignored, so bursts never change slave.
- IDLE: hsel=0 and default_slv_sel=0.
- Burst register loads on NONSEQ with hready=1.
- FSM tracks the data phase. States:
  - DP_IDLE
  - DP_SLV
  - DP_ERR
- FSM transitions, evaluated only when hready=1:
  - htrans is IDLE/BUSY -> DP_IDLE
  - NONSEQ/SEQ with a slave select -> DP_SLV
  - NONSEQ/SEQ with default select -> DP_ERR
  - When hready=0, state and all data-phase registers hold.
- Data-phase outputs: hsel_dp loads hsel, and default_slv_dp loads default_slv_sel, when hready=1.
- hsel_dp=0 in DP_IDLE and DP_ERR. default_slv_dp=1 only in DP_ERR.
- dec_err_cnt increments by 1 on each entry into a DP_ERR data phase (hready=1 with default select). It saturates at 2^CNT_W-1 with no wrap.
- split_pend[i] is set when hsel_dp[i]=1, hresp=SPLIT and hready=1. It is cleared when hsplit[i]=1.
  - If set and clear happen in the same cycle, set wins.
  - split_pend does not gate hsel; the arbiter consumes it.
- remap_act loads hremap only when the FSM is in DP_IDLE and htrans=IDLE. Otherwise it holds, so remap never changes mid-burst or mid-transfer.

## Timing
- Reset (hreset=1 at a hclk edge) sets:
  - state=DP_IDLE
  - hsel_dp=0, default_slv_dp=0
  - split_pend=0
  - remap_act=0
  - dec_err_cnt=0
  - burst register=0
- During reset, hsel and default_slv_sel are forced to 0.
- Reset mid-transfer aborts the transfer. Outputs are zero the cycle after.
- hsel/default_slv_sel: 0-cycle (combinational) from haddr/htrans, or from the burst register.
- Data-phase outputs: 1 cycle after the address phase that completes with hready=1. Wait states extend the data phase by holding them.
- At most one of hsel and default_slv_sel is asserted in any cycle. The same holds for hsel_dp and default_slv_dp.
- Error counter and split_pend update on the same edge that enters/samples the data phase.

## Test plan
- Map: slave0 0x0000_0000/mask 0xFFFF_0000, slave1 0x0001_0000/mask 0xFFFF_0000. Drive NONSEQ 0x0001_0010 with hready=1 -> hsel=4'b0010 the same cycle, hsel_dp=4'b0010 the next cycle, state DP_SLV.
- NONSEQ 0x0001_0000 followed by SEQ 0x0000_0004, wait states hready=0 for 2 cycles -> hsel stays 4'b0010 throughout; hsel_dp holds 4'b0010 during the waits.
- NONSEQ 0x8000_0000 (unmapped), repeated 300 times with CNT_W=8 -> default_slv_sel=1, default_slv_dp=1 the next cycle, hsel_dp=0, dec_err_cnt stops at 255.
- Assert hremap=1 during an active burst -> remap_act stays 0 until the first htrans=IDLE in DP_IDLE. Then NONSEQ 0x0000_0000 -> hsel=4'b0010.
- Slave 2 data phase with hresp=SPLIT, hready=1 -> split_pend[2]=1 the next cycle. hsplit[2] pulse -> 0 one cycle later. Set and clear in the same cycle -> stays 1.
- hreset=1 during a DP_ERR data phase -> all registered outputs are 0 after the edge, and dec_err_cnt=0.
